// File: rtl/rnd_word_serializer.sv
// Captures one fresh random vector per request and streams it LSW-first as WORD-wide words.
// A vector equal to the previous capture or to the post-reset all-ones value is never used.
module rnd_word_serializer #(
  parameter int BIT     = 512,
  parameter int WORD    = 32,
  parameter int TIMEOUT = 256,
  localparam int NW     = BIT / WORD,
  localparam int IW     = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [BIT-1:0]  rnd_in,
  input  logic            req,
  output logic            busy,
  output logic            word_valid,
  input  logic            word_ready,
  output logic [WORD-1:0] word_data,
  output logic [IW-1:0]   word_idx,
  output logic            word_last,
  output logic            done,
  output logic            err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t          state, state_nxt;
  logic [BIT-1:0]  sr;
  logic [BIT-1:0]  last_seen;
  logic [IW-1:0]   wcnt;
  logic [TW-1:0]   tcnt;
  logic            err_q;

  logic            fresh;
  logic            capture;
  logic            shift;
  logic            tcnt_clr;
  logic            tcnt_inc;
  logic            err_set;
  logic            is_last;

  assign fresh   = (rnd_in != last_seen) && (rnd_in != {BIT{1'b1}});
  assign is_last = (wcnt == IW'(NW - 1));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift     = 1'b0;
    tcnt_clr  = 1'b0;
    tcnt_inc  = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_WAIT;
          tcnt_clr  = 1'b1;
        end
      end
      S_WAIT: begin
        if (fresh) begin
          capture   = 1'b1;
          state_nxt = S_SEND;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tcnt_inc  = 1'b1;
        end
      end
      S_SEND: begin
        if (word_ready) begin
          shift = 1'b1;
          if (is_last) state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      sr        <= '0;
      last_seen <= {BIT{1'b1}};
      wcnt      <= '0;
      tcnt      <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      if (tcnt_clr) tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + TW'(1);
      // last_seen only moves on capture, so a stale vector keeps WAIT spinning
      if (capture) begin
        sr        <= rnd_in;
        last_seen <= rnd_in;
        wcnt      <= '0;
      end else if (shift) begin
        sr   <= sr >> WORD;
        wcnt <= wcnt + IW'(1);
      end
    end
  end

  assign busy       = (state == S_WAIT) || (state == S_SEND);
  assign word_valid = (state == S_SEND);
  assign word_data  = word_valid ? sr[WORD-1:0] : '0;
  assign word_idx   = word_valid ? wcnt : '0;
  assign word_last  = word_valid && is_last;
  assign done       = (state == S_FIN);
  assign err        = err_q;

endmodule

// File: tb/tb_rnd_word_serializer.sv
// Directed bench for rnd_word_serializer at default parameters (512/32/256).
module tb_rnd_word_serializer;

  logic         clk = 1'b0;
  logic         rstn;
  logic [511:0] rnd_in;
  logic         req;
  logic         busy;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic [3:0]   word_idx;
  logic         word_last;
  logic         done;
  logic         err;

  int checks = 0;
  int fails  = 0;

  rnd_word_serializer dut (
    .clk        (clk),
    .rstn       (rstn),
    .rnd_in     (rnd_in),
    .req        (req),
    .busy       (busy),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [511:0] mkvec(input logic [31:0] base);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic pulse_req;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req = 1'b0; word_ready = 1'b0; rnd_in = '1;
    tick(); tick();
    checks++;
    if ({busy, word_valid, word_last, done, err} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {busy, word_valid, word_last, done, err});
    end
    checks++;
    if (word_data !== 32'h0 || word_idx !== 4'h0) begin
      fails++; $display("FAIL reset_data: got data=%h idx=%0d want 0/0", word_data, word_idx);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_timeout;
    int bad = 0;
    rnd_in = '1;
    pulse_req();
    for (int k = 1; k < 257; k++) begin
      if (err !== 1'b0 || word_valid !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL timeout_wait: %0d bad cycles before err, want 0", bad);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_err: err=%b busy=%b at cycle 257, want 1/0", err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL timeout_pulse: err=%b one cycle later, want 0", err);
    end
  endtask

  task automatic stream_check(input logic [31:0] base, input string tag);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (word_valid !== 1'b1 || word_data !== base + 32'(i) || word_idx !== 4'(i)
          || word_last !== (i == 15) || done !== 1'b0) begin
        fails++;
        $display("FAIL %s_word%0d: v=%b data=%h idx=%0d last=%b done=%b want 1/%h/%0d/%b/0",
                 tag, i, word_valid, word_data, word_idx, word_last, done, base + 32'(i), i, i == 15);
      end
      tick();
    end
    checks++;
    if (word_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_done: v=%b done=%b busy=%b want 0/1/0", tag, word_valid, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL %s_done_pulse: done=%b want 0", tag, done);
    end
  endtask

  task automatic test_stream;
    rnd_in = mkvec(32'h0);
    word_ready = 1'b1;
    pulse_req();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL stream_latency1: v=%b busy=%b want 0/1", word_valid, busy);
    end
    tick();
    stream_check(32'h0, "stream");
  endtask

  task automatic test_stall;
    int n = 0;
    int c = 0;
    int dseen = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    rnd_in = mkvec(32'hA000_0000);
    pulse_req();
    while (c < 200 && dseen == 0) begin
      if (done === 1'b1) dseen++;
      else if (word_valid === 1'b1) begin
        checks++;
        if (word_data !== 32'hA000_0000 + 32'(n) || word_idx !== 4'(n) || word_last !== (n == 15)) begin
          fails++; $display("FAIL stall_word%0d: data=%h idx=%0d last=%b", n, word_data, word_idx, word_last);
        end
        if (prev_stall) begin
          checks++;
          if (word_data !== prev_data) begin
            fails++; $display("FAIL stall_hold: data=%h want %h", word_data, prev_data);
          end
        end
      end
      word_ready = (c % 3 == 0);
      if (word_valid === 1'b1 && word_ready) n++;
      prev_stall = word_valid && !word_ready;
      prev_data  = word_data;
      c++;
      tick();
    end
    word_ready = 1'b1;
    checks++;
    if (n != 16 || dseen != 1) begin
      fails++; $display("FAIL stall_total: words=%0d done=%0d want 16/1", n, dseen);
    end
  endtask

  task automatic test_stale;
    int bad = 0;
    pulse_req();
    for (int k = 1; k <= 40; k++) begin
      if (busy !== 1'b1 || word_valid !== 1'b0) bad++;
      if (k == 40) rnd_in = mkvec(32'h5500_0000);
      tick();
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL stale_wait: %0d bad cycles, want 0", bad);
    end
    stream_check(32'h5500_0000, "stale");
  endtask

  task automatic test_req_during_send;
    int dcnt = 0;
    int words = 0;
    int drop = 0;
    rnd_in = mkvec(32'h7700_0000);
    pulse_req();
    for (int c = 1; c <= 25; c++) begin
      if (c <= 17 && busy !== 1'b1) drop++;
      if (done === 1'b1) dcnt++;
      if (word_valid === 1'b1) words++;
      req = (c == 6);
      tick();
    end
    req = 1'b0;
    checks++;
    if (dcnt != 1 || words != 16 || drop != 0) begin
      fails++; $display("FAIL req_in_send: done=%0d words=%0d busy_drops=%0d want 1/16/0", dcnt, words, drop);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL req_in_send_queued: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    int c = 0;
    rnd_in = mkvec(32'h3300_0000);
    pulse_req();
    repeat (7) tick();
    checks++;
    if (word_idx !== 4'd6 || word_data !== 32'h3300_0006) begin
      fails++; $display("FAIL midrst_pre: idx=%0d data=%h want 6/33000006", word_idx, word_data);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, word_valid, word_last, done, err} !== 5'b0 || word_data !== 32'h0 || word_idx !== 4'h0) begin
      fails++; $display("FAIL midrst_async: flags=%b data=%h idx=%0d want 0", {busy, word_valid, word_last, done, err}, word_data, word_idx);
    end
    repeat (3) begin
      tick();
      if (done !== 1'b0 || err !== 1'b0 || word_valid !== 1'b0) bad++;
    end
    rstn = 1'b1;
    tick();
    if (done !== 1'b0 || err !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL midrst_pulses: %0d bad cycles, want 0", bad);
    end
    pulse_req();
    tick();
    checks++;
    if (word_valid !== 1'b1 || word_idx !== 4'd0 || word_data !== 32'h3300_0000) begin
      fails++; $display("FAIL midrst_restart: v=%b idx=%0d data=%h want 1/0/33000000", word_valid, word_idx, word_data);
    end
    while (done !== 1'b1 && c < 40) begin
      tick(); c++;
    end
    checks++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL midrst_finish: done not seen within 40 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_stream();
    test_stall();
    test_stale();
    test_req_during_send();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rnd_word_serializer.md
Name: rnd_word_serializer

Overview:
- Sits directly downstream of the LFSR random number generator in the EVENT_SAVE_UFM path.
- The generator publishes a BIT-wide random vector roughly every 33 clocks.
- On request, this block captures one fresh vector and streams it out as WORD-wide words over a valid/ready handshake to the UFM write sequencer.
- It guarantees that no vector is used twice and that the generator's post-reset all-ones value is never used.

Parameters:
- BIT, 512, width of the upstream random vector; must be an integer multiple of WORD.
- WORD, 32, output word width.
- TIMEOUT, 256, maximum number of clocks to wait for a fresh vector before reporting an error.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- rnd_in  in  BIT  random vector from the generator.
- req  in  1  single-cycle request for one full vector; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted req until done/err.
- word_valid  out  1  word_data holds a valid word.
- word_ready  in  1  downstream accepts the word this cycle.
- word_data  out  WORD  current output word.
- word_idx  out  IW  index of the current word, 0..BIT/WORD-1; IW = clog2(BIT/WORD), minimum 1.
- word_last  out  1  high together with word_valid on the final word.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse on fresh-vector timeout.

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_seen register = all ones.
  - Shift register, word counter and timeout counter = 0.
- Fresh detection, evaluated every cycle in every state:
  - fresh = (rnd_in != last_seen) && (rnd_in != all ones).
  - last_seen is updated only when a vector is captured.
- State machine (IDLE, WAIT, SEND, FIN):
  - IDLE:
    - req=1 → WAIT, busy=1 next cycle, timeout counter cleared.
    - req=0 → stay in IDLE.
  - WAIT:
    - If fresh: capture rnd_in into the shift register and last_seen, clear the word counter, go to SEND.
    - Otherwise increment the timeout counter.
    - When the counter reaches TIMEOUT-1 without a fresh vector: pulse err for 1 cycle, busy=0, go to IDLE. Nothing is captured.
  - SEND:
    - word_valid=1; word_data = shift register [WORD-1:0]; least-significant word first.
    - word_idx = word counter; word_last = (counter == BIT/WORD-1).
    - On word_valid && word_ready: shift the register right by WORD and increment the counter.
    - Accepting the last word → FIN, with word_valid=0 the next cycle.
    - While word_ready=0, word_data, word_idx and word_last stay stable; word_valid is never withdrawn.
  - FIN:
    - Pulse done for 1 cycle, busy=0, go to IDLE.
    - A new req can be accepted on the cycle after done.
- Latency:
  - req to first word_valid is at least 2 clocks: 1 into WAIT, at least 1 capture.
  - If rnd_in is already fresh on WAIT entry, word_valid rises 2 cycles after req.
- Throughput: with word_ready held high, one word per clock; BIT/WORD words in consecutive cycles.
- Boundary conditions:
  - req while busy: ignored, no queuing.
  - rnd_in changes during SEND: no effect on the words in flight.
  - A second request before the generator updates: waits in WAIT until rnd_in differs from last_seen.
  - Generator output still all ones after reset: never captured; leads to timeout if it persists.
  - rstn asserted mid-transfer: immediate return to the reset values; the partial transfer is abandoned with no done or err pulse.
  - err and done are mutually exclusive and never assert in the same cycle as word_valid.

Test Plan:
- Reset, then rnd_in = all ones held, req pulse → no word_valid; err pulses exactly TIMEOUT+1 cycles after req (default 257); busy falls with it; last_seen stays all ones.
- rnd_in = 512'h0123…(pattern i in word i), word_ready=1, req → word_valid 2 cycles after req; 16 consecutive words with word_data=i and word_idx=i; word_last only on idx 15; done 1 cycle after idx 15.
- Same vector with word_ready toggled 1,0,0,1… → each word held stable across stall cycles; order preserved; total accepted words = 16; no duplicates.
- Complete one transfer, then issue req again without changing rnd_in → stays in WAIT; change rnd_in after 40 cycles → capture occurs the cycle after the change; the new words are streamed.
- req pulsed during SEND → ignored; exactly one done; busy never drops mid-transfer.
- rstn asserted after word 5 is accepted → all outputs 0 asynchronously; no done or err; a subsequent req with a fresh rnd_in restarts at word_idx 0.
